tick_pwm: RTL and testbench

- Downstream consumer of the divider's single-cycle `imp` strobe.
- Produces a PWM waveform whose time base is that strobe rather than the raw clock, so period and duty are counted in ticks.
- Period and duty are programmed through a valid/ready config port into a shadow register. The shadow is applied glitch-free, only at a period boundary.
- Sits between the clock-divider/impulse stage and LED/actuator drive logic.

---
 rtl/pwm_pkg.sv | 17 +
 rtl/pwm_cfg_shadow.sv | 43 ++++
 rtl/tick_pwm.sv | 134 +++++++++++++
 tb/tb_tick_pwm.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types for the tick-based PWM: FSM state encoding, default counter
// width and the period/duty config record.
package pwm_pkg;

    localparam int PWM_CNT_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [PWM_CNT_W-1:0] period;
        logic [PWM_CNT_W-1:0] duty;
    } cfg_t;

endpackage

// File: rtl/pwm_cfg_shadow.sv
// Valid/ready config shadow: holds one period/duty pair until the PWM FSM
// reports a boundary, then raises apply for that cycle and frees the slot.
module pwm_cfg_shadow
    import pwm_pkg::*;
#(
    parameter int CNT_W = PWM_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_duty,
    input  logic             capture,
    input  logic             boundary,
    output logic             cfg_ready,
    output logic             accept,
    output logic             apply,
    output logic [CNT_W-1:0] shadow_period,
    output logic [CNT_W-1:0] shadow_duty
);

    logic pending;

    assign cfg_ready = ~pending;
    assign accept    = cfg_valid & ~pending;
    // accept and apply are mutually exclusive: one needs pending low, the other high
    assign apply     = pending & boundary;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending       <= 1'b0;
            shadow_period <= '0;
            shadow_duty   <= '0;
        end else if (apply) begin
            pending <= 1'b0;
        end else if (accept && capture) begin
            pending       <= 1'b1;
            shadow_period <= cfg_period;
            shadow_duty   <= cfg_duty;
        end
    end

endmodule

// File: rtl/tick_pwm.sv
// PWM generator whose time base is the divider's tick strobe; period and duty
// are counted in ticks and reprogrammed glitch-free at period boundaries.
module tick_pwm
    import pwm_pkg::*;
#(
    parameter int CNT_W      = PWM_CNT_W,
    parameter int DEF_PERIOD = 9,
    parameter int DEF_DUTY   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             enable,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_duty,
    output logic             pwm_out,
    output logic             period_done
);

    localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0] DEF_D = CNT_W'(DEF_DUTY);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    state_e           state, state_nxt;
    logic [CNT_W-1:0] counter, counter_nxt;
    logic [CNT_W-1:0] period_act, duty_act;
    logic [CNT_W-1:0] shadow_period, shadow_duty, duty_eff;
    logic             pwm_nxt, done_nxt;
    logic             at_end, wrap, stop, boundary;
    logic             accept, apply;

    assign at_end = (counter == period_act);
    assign wrap   = (state == RUN) && enable && tick && at_end;
    assign stop   = (state == RUN) && !enable;
    // IDLE also counts as a boundary so a config caught on the enable-drop
    // edge is applied on the next cycle instead of blocking the port.
    assign boundary = wrap || stop || (state == IDLE);

    pwm_cfg_shadow #(.CNT_W(CNT_W)) u_shadow (
        .clk          (clk),
        .reset        (reset),
        .cfg_valid    (cfg_valid),
        .cfg_period   (cfg_period),
        .cfg_duty     (cfg_duty),
        .capture      (state == RUN),
        .boundary     (boundary),
        .cfg_ready    (cfg_ready),
        .accept       (accept),
        .apply        (apply),
        .shadow_period(shadow_period),
        .shadow_duty  (shadow_duty)
    );

    assign duty_eff = apply ? shadow_duty : duty_act;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable)  state_nxt = RUN;
            RUN:     if (!enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        counter_nxt = counter;
        pwm_nxt     = pwm_out;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                counter_nxt = '0;
                pwm_nxt     = enable && (duty_eff != '0);
            end
            RUN: begin
                if (!enable) begin
                    counter_nxt = '0;
                    pwm_nxt     = 1'b0;
                end else if (tick) begin
                    if (at_end) begin
                        counter_nxt = '0;
                        done_nxt    = 1'b1;
                        pwm_nxt     = (duty_eff != '0);
                    end else begin
                        counter_nxt = counter + ONE;
                        pwm_nxt     = ((counter + ONE) < duty_act);
                    end
                end
            end
            default: begin
                counter_nxt = '0;
                pwm_nxt     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter     <= '0;
            pwm_out     <= 1'b0;
            period_done <= 1'b0;
        end else begin
            counter     <= counter_nxt;
            pwm_out     <= pwm_nxt;
            period_done <= done_nxt;
        end
    end

    // Active registers: shadow copy at a boundary, or a direct write while idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period_act <= DEF_P;
            duty_act   <= DEF_D;
        end else if (apply) begin
            period_act <= shadow_period;
            duty_act   <= shadow_duty;
        end else if (accept && state == IDLE) begin
            period_act <= cfg_period;
            duty_act   <= cfg_duty;
        end
    end

    a_counter_range: assert property (@(posedge clk) disable iff (!reset)
        counter <= period_act);
    a_idle_quiet: assert property (@(posedge clk) disable iff (!reset)
        (state == IDLE) |-> (counter == '0 && !period_done));

endmodule

// File: tb/tb_tick_pwm.sv
// Directed bench for tick_pwm: tick-timed waveforms, shadow config handoff,
// duty/period boundaries, enable drop and asynchronous reset.
module tb_tick_pwm;
    import pwm_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       enable;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_period;
    logic [7:0] cfg_duty;
    logic       pwm_out;
    logic       period_done;

    int n_chk  = 0;
    int n_fail = 0;

    tick_pwm #(.CNT_W(8), .DEF_PERIOD(9), .DEF_DUTY(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .enable     (enable),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_duty   (cfg_duty),
        .pwm_out    (pwm_out),
        .period_done(period_done)
    );

    always #5 clk = ~clk;

    // One clock with tick driven to t; returns 1 time unit after the edge.
    task automatic clk_cycle(input logic t);
        tick = t;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic send_cfg(input logic [7:0] p, input logic [7:0] d);
        cfg_valid  = 1'b1;
        cfg_period = p;
        cfg_duty   = d;
        clk_cycle(1'b0);
        cfg_valid  = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0; tick = 1'b0; enable = 1'b0;
        cfg_valid = 1'b0; cfg_period = '0; cfg_duty = '0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL reset_pwm: got %b expected 0", pwm_out); end
        n_chk++; if (period_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", period_done); end
        n_chk++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", cfg_ready); end
        reset = 1'b1;
        clk_cycle(1'b0);
    endtask

    // Direct load while idle, then a 2-tick period with duty 1
    task automatic test_idle_load;
        send_cfg(8'd1, 8'd1);
        n_chk++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %b expected 1", cfg_ready); end
        enable = 1'b1;
        clk_cycle(1'b0);
        n_chk++; if (pwm_out !== 1'b1) begin n_fail++; $display("FAIL idle_start_pwm: got %b expected 1", pwm_out); end
        clk_cycle(1'b1);
        n_chk++; if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL idle_t1_pwm: got %b expected 0", pwm_out); end
        clk_cycle(1'b1);
        n_chk++; if (pwm_out !== 1'b1 || period_done !== 1'b1) begin n_fail++; $display("FAIL idle_wrap: got pwm=%b done=%b expected pwm=1 done=1", pwm_out, period_done); end
        enable = 1'b0;
        clk_cycle(1'b0);
        n_chk++; if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL idle_stop_pwm: got %b expected 0", pwm_out); end
        send_cfg(8'd9, 8'd5);
    endtask

    // Period 10 ticks, duty 5, tick every third clock
    task automatic test_default;
        bit ep, ed;
        enable = 1'b1;
        clk_cycle(1'b0);
        n_chk++; if (pwm_out !== 1'b1) begin n_fail++; $display("FAIL default_start: got %b expected 1", pwm_out); end
        for (int k = 1; k <= 20; k++) begin
            clk_cycle(1'b0);
            clk_cycle(1'b0);
            n_chk++; if (period_done !== 1'b0) begin n_fail++; $display("FAIL default_gap_done k=%0d: got %b expected 0", k, period_done); end
            clk_cycle(1'b1);
            ep = (k % 10) < 5;
            ed = (k % 10) == 0;
            n_chk++; if (pwm_out !== ep) begin n_fail++; $display("FAIL default_pwm k=%0d: got %b expected %b", k, pwm_out, ep); end
            n_chk++; if (period_done !== ed) begin n_fail++; $display("FAIL default_done k=%0d: got %b expected %b", k, period_done, ed); end
        end
    endtask

    // Shadow update mid-period; a request held across the wrap is taken only afterwards
    task automatic test_cfg_update;
        bit ep;
        repeat (3) clk_cycle(1'b1);
        send_cfg(8'd3, 8'd1);
        n_chk++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL upd_ready_after_accept: got %b expected 0", cfg_ready); end
        for (int k = 4; k <= 9; k++) begin
            clk_cycle(1'b1);
            ep = k < 5;
            n_chk++; if (pwm_out !== ep || period_done !== 1'b0 || cfg_ready !== 1'b0) begin n_fail++; $display("FAIL upd_old_period k=%0d: got pwm=%b done=%b ready=%b expected pwm=%b done=0 ready=0", k, pwm_out, period_done, cfg_ready, ep); end
        end
        cfg_valid = 1'b1; cfg_period = 8'd9; cfg_duty = 8'd0;
        clk_cycle(1'b1);
        n_chk++; if (pwm_out !== 1'b1 || period_done !== 1'b1) begin n_fail++; $display("FAIL upd_wrap: got pwm=%b done=%b expected pwm=1 done=1", pwm_out, period_done); end
        n_chk++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL upd_ready_after_wrap: got %b expected 1", cfg_ready); end
        clk_cycle(1'b0);
        cfg_valid = 1'b0;
        n_chk++; if (cfg_ready !== 1'b0 || period_done !== 1'b0) begin n_fail++; $display("FAIL upd_second_accept: got ready=%b done=%b expected ready=0 done=0", cfg_ready, period_done); end
        for (int k = 1; k <= 4; k++) begin
            clk_cycle(1'b1);
            n_chk++; if (pwm_out !== 1'b0 || period_done !== (k == 4)) begin n_fail++; $display("FAIL upd_new_period k=%0d: got pwm=%b done=%b expected pwm=0 done=%b", k, pwm_out, period_done, k == 4); end
        end
        n_chk++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL upd_ready_final: got %b expected 1", cfg_ready); end
    endtask

    // duty=0 then duty=12 with period 9
    task automatic test_duty_bounds;
        bit ep;
        for (int k = 1; k <= 10; k++) begin
            clk_cycle(1'b1);
            n_chk++; if (pwm_out !== 1'b0 || period_done !== (k == 10)) begin n_fail++; $display("FAIL duty0 k=%0d: got pwm=%b done=%b expected pwm=0 done=%b", k, pwm_out, period_done, k == 10); end
        end
        send_cfg(8'd9, 8'd12);
        for (int k = 1; k <= 20; k++) begin
            clk_cycle(1'b1);
            ep = k >= 10;
            n_chk++; if (pwm_out !== ep || period_done !== (k % 10 == 0)) begin n_fail++; $display("FAIL duty12 k=%0d: got pwm=%b done=%b expected pwm=%b done=%b", k, pwm_out, period_done, ep, k % 10 == 0); end
        end
    endtask

    // period=0: every tick wraps
    task automatic test_period_zero;
        send_cfg(8'd0, 8'd3);
        repeat (9) clk_cycle(1'b1);
        for (int k = 1; k <= 6; k++) begin
            clk_cycle(1'b1);
            n_chk++; if (pwm_out !== 1'b1 || period_done !== 1'b1) begin n_fail++; $display("FAIL p0_duty3 k=%0d: got pwm=%b done=%b expected pwm=1 done=1", k, pwm_out, period_done); end
        end
        send_cfg(8'd0, 8'd0);
        n_chk++; if (period_done !== 1'b0) begin n_fail++; $display("FAIL p0_notick_done: got %b expected 0", period_done); end
        for (int k = 1; k <= 4; k++) begin
            clk_cycle(1'b1);
            n_chk++; if (pwm_out !== 1'b0 || period_done !== 1'b1) begin n_fail++; $display("FAIL p0_duty0 k=%0d: got pwm=%b done=%b expected pwm=0 done=1", k, pwm_out, period_done); end
        end
    endtask

    // enable falls at counter 6 with cfg(4,2) pending; tick on the same edge is ignored
    task automatic test_enable_drop;
        bit ep, ed;
        send_cfg(8'd9, 8'd5);
        clk_cycle(1'b1);
        for (int k = 1; k <= 6; k++) begin
            clk_cycle(1'b1);
            ep = k < 5;
            n_chk++; if (pwm_out !== ep || period_done !== 1'b0) begin n_fail++; $display("FAIL drop_pre k=%0d: got pwm=%b done=%b expected pwm=%b done=0", k, pwm_out, period_done, ep); end
        end
        send_cfg(8'd4, 8'd2);
        n_chk++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL drop_pending: got %b expected 0", cfg_ready); end
        enable = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            clk_cycle(1'b1);
            n_chk++; if (pwm_out !== 1'b0 || period_done !== 1'b0 || cfg_ready !== 1'b1) begin n_fail++; $display("FAIL drop_idle k=%0d: got pwm=%b done=%b ready=%b expected pwm=0 done=0 ready=1", k, pwm_out, period_done, cfg_ready); end
        end
        enable = 1'b1;
        clk_cycle(1'b0);
        n_chk++; if (pwm_out !== 1'b1) begin n_fail++; $display("FAIL drop_restart: got %b expected 1", pwm_out); end
        for (int k = 1; k <= 10; k++) begin
            clk_cycle(1'b1);
            ep = (k % 5) < 2;
            ed = (k % 5) == 0;
            n_chk++; if (pwm_out !== ep || period_done !== ed) begin n_fail++; $display("FAIL drop_new k=%0d: got pwm=%b done=%b expected pwm=%b done=%b", k, pwm_out, period_done, ep, ed); end
        end
    endtask

    // Asynchronous reset during the high phase with a pending config
    task automatic test_async_reset;
        bit ep, ed;
        send_cfg(8'd0, 8'd0);
        n_chk++; if (pwm_out !== 1'b1 || cfg_ready !== 1'b0) begin n_fail++; $display("FAIL ar_pre: got pwm=%b ready=%b expected pwm=1 ready=0", pwm_out, cfg_ready); end
        #2 reset = 1'b0;
        #1;
        n_chk++; if (pwm_out !== 1'b0 || cfg_ready !== 1'b1 || period_done !== 1'b0) begin n_fail++; $display("FAIL ar_immediate: got pwm=%b ready=%b done=%b expected pwm=0 ready=1 done=0", pwm_out, cfg_ready, period_done); end
        clk_cycle(1'b1);
        clk_cycle(1'b1);
        reset = 1'b1;
        clk_cycle(1'b0);
        n_chk++; if (pwm_out !== 1'b1 || cfg_ready !== 1'b1) begin n_fail++; $display("FAIL ar_restart: got pwm=%b ready=%b expected pwm=1 ready=1", pwm_out, cfg_ready); end
        for (int k = 1; k <= 10; k++) begin
            clk_cycle(1'b1);
            ep = (k % 10) < 5;
            ed = (k % 10) == 0;
            n_chk++; if (pwm_out !== ep || period_done !== ed) begin n_fail++; $display("FAIL ar_default k=%0d: got pwm=%b done=%b expected pwm=%b done=%b", k, pwm_out, period_done, ep, ed); end
        end
    endtask

    initial begin
        test_reset();
        test_idle_load();
        test_default();
        test_cfg_update();
        test_duty_bounds();
        test_period_zero();
        test_enable_drop();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
